// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC register access sequencer: mode encodings,
// sequencer states and default widths.
package rtc_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int N_CH_DEF    = 7;
  localparam int IDX_W_DEF   = 3;
  localparam int TIMEOUT_DEF = 255;

  localparam logic [1:0] MODE_BRD = 2'b00;
  localparam logic [1:0] MODE_BWR = 2'b01;
  localparam logic [1:0] MODE_SRD = 2'b10;
  localparam logic [1:0] MODE_SWR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  function automatic logic is_burst(input logic [1:0] m);
    return (m == MODE_BRD) || (m == MODE_BWR);
  endfunction

endpackage

// File: rtl/rtc_shadow_bank.sv
// Per-channel shadow register file: one write port, a combinational read port
// (forwarding same-cycle writes) for bus write data, and a registered read port.
module rtc_shadow_bank
  import rtc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_CH   = N_CH_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  int_idx_i,
  output logic [DATA_W-1:0] int_data_o,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_val_o
);

  localparam int              IW1   = IDX_W + 1;
  localparam logic [IDX_W:0]  NCH_L = IW1'(N_CH);

  logic [DATA_W-1:0] mem_q [N_CH];
  logic [DATA_W-1:0] rd_val_q;

  // Storage array; out-of-range write indices are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i && ({1'b0, wr_idx_i} < NCH_L)) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end else begin
      mem_q <= mem_q;
    end
  end

  // A write in the same cycle wins so a burst write started alongside wr_load sends the new value
  always_comb begin
    int_data_o = '0;
    if (wr_en_i && (wr_idx_i == int_idx_i)) begin
      int_data_o = wr_data_i;
    end else if ({1'b0, int_idx_i} < NCH_L) begin
      int_data_o = mem_q[int_idx_i];
    end else begin
      int_data_o = '0;
    end
  end

  // Registered shadow read-back
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_val_q <= '0;
    end else if ({1'b0, rd_idx_i} < NCH_L) begin
      rd_val_q <= mem_q[rd_idx_i];
    end else begin
      rd_val_q <= '0;
    end
  end

  assign rd_val_o = rd_val_q;

endmodule

// File: rtl/rtc_access_seq.sv
// RTC register access sequencer: single/burst reads and writes over a req/ack
// handshake with per-transfer timeout; all outputs are registered.
module rtc_access_seq
  import rtc_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int N_CH    = N_CH_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [IDX_W-1:0]  idx,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wr_load,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_val,
  output logic              req,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int             TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);
  localparam int             IW1   = IDX_W + 1;
  localparam logic [IDX_W:0] NCH_L = IW1'(N_CH);
  localparam logic [IDX_W:0] CLAST = IW1'(N_CH - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              err_q, err_d;
  logic [1:0]        mode_q, mode_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              sh_we;
  logic [IDX_W-1:0]  sh_widx;
  logic [DATA_W-1:0] sh_wdata;
  logic [DATA_W-1:0] sh_int_data;

  rtc_shadow_bank #(
    .DATA_W (DATA_W),
    .N_CH   (N_CH),
    .IDX_W  (IDX_W)
  ) u_bank (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (sh_we),
    .wr_idx_i   (sh_widx),
    .wr_data_i  (sh_wdata),
    .int_idx_i  (cnt_d),
    .int_data_o (sh_int_data),
    .rd_idx_i   (rd_idx),
    .rd_val_o   (rd_val)
  );

  // Sequencer state, latched request and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      err_q       <= 1'b0;
      mode_q      <= 2'b00;
      idx_q       <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      bus_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      err_q       <= err_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      bus_wdata_q <= bus_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic, timeout counting and shadow write requests
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    err_d    = err_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    sh_we    = 1'b0;
    sh_widx  = idx;
    sh_wdata = wdata;
    case (state_q)
      ST_IDLE: begin
        sh_we = wr_load;
        if (start) begin
          mode_d  = mode;
          idx_d   = idx;
          base_d  = base_addr;
          wdata_d = wdata;
          tcnt_d  = '0;
          if (is_burst(mode)) begin
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = ST_ISSUE;
          end else if ({1'b0, idx} < NCH_L) begin
            cnt_d   = idx;
            err_d   = 1'b0;
            state_d = ST_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        // ISSUE is already a req-high cycle, so ack is accepted there too
        if (ack) begin
          if (!mode_q[0]) begin
            sh_we    = 1'b1;
            sh_widx  = cnt_q;
            sh_wdata = bus_rdata;
          end else if (mode_q == MODE_SWR) begin
            sh_we    = 1'b1;
            sh_widx  = idx_q;
            sh_wdata = wdata_q;
          end else begin
            sh_we = 1'b0;
          end
          if (is_burst(mode_q) && ({1'b0, cnt_q} < CLAST)) begin
            cnt_d   = cnt_q + IDX_W'(1);
            state_d = ST_GAP;
          end else begin
            state_d = ST_FINISH;
          end
        end else if (tcnt_q == TLAST) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          tcnt_d  = tcnt_q + TW'(1);
          state_d = ST_WAIT;
        end
      end
      ST_GAP: begin
        tcnt_d  = '0;
        state_d = ST_ISSUE;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus-side output values for the coming cycle, derived from the next state
  always_comb begin
    req_d       = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    busy_d      = req_d || (state_d == ST_GAP);
    done_d      = (state_d == ST_FINISH);
    we_d        = 1'b0;
    addr_d      = '0;
    bus_wdata_d = '0;
    if (req_d) begin
      we_d   = mode_d[0];
      addr_d = base_d + ADDR_W'(cnt_d);
      if (mode_d == MODE_BWR) begin
        bus_wdata_d = sh_int_data;
      end else if (mode_d == MODE_SWR) begin
        bus_wdata_d = wdata_d;
      end else begin
        bus_wdata_d = '0;
      end
    end else begin
      we_d = 1'b0;
    end
  end

  assign req       = req_q;
  assign we        = we_q;
  assign addr      = addr_q;
  assign bus_wdata = bus_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rtc_access_seq.sv
// Self-checking bench for rtc_access_seq: directed scenarios plus randomized
// transactions checked against a transfer-level model of the shadow bank.
module tb_rtc_access_seq;

  localparam int NCH = 7;
  localparam int TO  = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic [2:0] idx;
  logic [7:0] base_addr;
  logic [7:0] wdata;
  logic       wr_load;
  logic [2:0] rd_idx;
  logic [7:0] rd_val;
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] bus_wdata;
  logic       ack;
  logic [7:0] bus_rdata;
  logic       busy;
  logic       done;
  logic       err;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] sh_m [8];
  logic       err_m;
  int         dly  [NCH];
  logic [7:0] rdat [NCH];

  rtc_access_seq #(
    .ADDR_W (8), .DATA_W (8), .N_CH (NCH), .IDX_W (3), .TIMEOUT (TO)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .mode (mode), .idx (idx),
    .base_addr (base_addr), .wdata (wdata), .wr_load (wr_load), .rd_idx (rd_idx),
    .rd_val (rd_val), .req (req), .we (we), .addr (addr), .bus_wdata (bus_wdata),
    .ack (ack), .bus_rdata (bus_rdata), .busy (busy), .done (done), .err (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input logic [7:0] v);
    @(negedge clk);
    wr_load = 1'b1; idx = 3'(i); wdata = v;
    @(posedge clk); #1;
    wr_load = 1'b0;
    if (i < NCH) sh_m[i] = v;
  endtask

  task automatic check_shadow(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rd_idx = 3'(i);
      @(posedge clk);
      @(negedge clk);
      chk(tag, {24'd0, rd_val}, (i < NCH) ? {24'd0, sh_m[i]} : 32'd0);
    end
  endtask

  // One transaction: drive start, play the ack delays in dly[], check every bus cycle.
  task automatic do_txn(input logic [1:0] m, input int ix, input logic [7:0] base,
                        input logic [7:0] wd, input bit noise, input bit ld, input int ld_idx);
    bit         burst, bad, aborted;
    int         nx, ch, d, ncyc;
    logic [7:0] e_wd;
    burst   = (m[1] == 1'b0);
    bad     = !burst && (ix >= NCH);
    aborted = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = m; idx = 3'(ix); base_addr = base; wdata = wd;
    if (ld) begin
      wr_load = 1'b1; idx = 3'(ld_idx); wdata = wd;
      if (ld_idx < NCH) sh_m[ld_idx] = wd;
    end
    @(posedge clk); #1;
    start = 1'b0; wr_load = 1'b0;
    if (noise) begin
      start = 1'b1; wr_load = 1'b1; mode = 2'($urandom); idx = 3'($urandom);
      base_addr = 8'($urandom); wdata = 8'($urandom);
    end
    if (bad) begin
      err_m = 1'b1;
      @(negedge clk);
      chk("bad_req", {31'd0, req}, 32'd0);
      chk("bad_done", {31'd0, done}, 32'd1);
      chk("bad_err", {31'd0, err}, 32'd1);
      start = 1'b0; wr_load = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("bad_done_end", {31'd0, done}, 32'd0);
      chk("bad_busy_end", {31'd0, busy}, 32'd0);
      return;
    end
    err_m = 1'b0;
    nx = burst ? NCH : 1;
    for (int k = 0; k < nx; k++) begin
      ch   = burst ? k : ix;
      d    = dly[k];
      ncyc = (d < TO) ? d + 1 : TO;
      if (m == 2'b01)      e_wd = sh_m[ch];
      else if (m == 2'b11) e_wd = wd;
      else                 e_wd = 8'd0;
      for (int c = 0; c < ncyc; c++) begin
        @(negedge clk);
        chk("req", {31'd0, req}, 32'd1);
        chk("addr", {24'd0, addr}, {24'd0, 8'(base + 8'(ch))});
        chk("we", {31'd0, we}, {31'd0, m[0]});
        chk("bus_wdata", {24'd0, bus_wdata}, {24'd0, e_wd});
        chk("busy", {31'd0, busy}, 32'd1);
        chk("err_clr", {31'd0, err}, 32'd0);
        chk("no_done", {31'd0, done}, 32'd0);
        ack = (c == d);
        bus_rdata = rdat[k];
        @(posedge clk); #1;
        ack = 1'b0;
        bus_rdata = 8'($urandom);
        if (c == d) begin
          if (m[0] == 1'b0) sh_m[ch] = rdat[k];
          else if (m == 2'b11) sh_m[ix] = wd;
        end
      end
      if (d >= TO) begin
        aborted = 1'b1;
        err_m   = 1'b1;
        break;
      end
      if (k < nx - 1) begin
        @(negedge clk);
        chk("gap_req", {31'd0, req}, 32'd0);
        chk("gap_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
      end
    end
    @(negedge clk);
    start = 1'b0; wr_load = 1'b0;
    chk("done", {31'd0, done}, 32'd1);
    chk("done_req", {31'd0, req}, 32'd0);
    chk("done_err", {31'd0, err}, {31'd0, err_m});
    @(posedge clk);
    @(negedge clk);
    chk(aborted ? "to_done_end" : "done_end", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_err", {31'd0, err}, {31'd0, err_m});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'b00; idx = 3'd0; base_addr = 8'd0;
    wdata = 8'd0; wr_load = 1'b0; rd_idx = 3'd0; ack = 1'b0; bus_rdata = 8'd0;
    err_m = 1'b0;
    for (int i = 0; i < 8; i++) sh_m[i] = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_addr", {24'd0, addr}, 32'd0);
    chk("rst_bus_wdata", {24'd0, bus_wdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rd_val", {24'd0, rd_val}, 32'd0);
    reset = 1'b0;

    // burst read, zero-wait, data 0x10+cnt
    for (int k = 0; k < NCH; k++) begin dly[k] = 0; rdat[k] = 8'(8'h10 + k); end
    do_txn(2'b00, 0, 8'h00, 8'h00, 1'b0, 1'b0, 0);
    check_shadow("shadow_brd");

    // burst write with address wrap
    for (int k = 0; k < NCH; k++) load(k, 8'(8'h30 + k));
    do_txn(2'b01, 0, 8'hFC, 8'h00, 1'b0, 1'b0, 0);

    // single write, ack after 4 wait cycles
    dly[0] = 4;
    do_txn(2'b11, 3, 8'h40, 8'h59, 1'b0, 1'b0, 0);
    check_shadow("shadow_swr");

    // single op with out-of-range index, then a valid single read clears err
    do_txn(2'b10, 7, 8'h00, 8'h00, 1'b0, 1'b0, 0);
    dly[0] = 1; rdat[0] = 8'hA5;
    do_txn(2'b10, 0, 8'h20, 8'h00, 1'b0, 1'b0, 0);

    // timeout on the first transfer of a burst read
    dly[0] = TO;
    do_txn(2'b00, 0, 8'h00, 8'h00, 1'b0, 1'b0, 0);
    check_shadow("shadow_to");

    // wr_load together with a burst write start, noise during the transaction
    for (int k = 0; k < NCH; k++) dly[k] = 0;
    do_txn(2'b01, 0, 8'h80, 8'hC3, 1'b1, 1'b1, 0);

    // randomized transactions
    for (int t = 0; t < 24; t++) begin
      logic [1:0] rm;
      int         rix;
      rm  = 2'($urandom);
      rix = int'($urandom_range(0, 7));
      for (int k = 0; k < NCH; k++) begin
        dly[k]  = ($urandom_range(0, 15) == 0) ? TO : int'($urandom_range(0, 3));
        rdat[k] = 8'($urandom);
      end
      if ($urandom_range(0, 2) == 0) load(int'($urandom_range(0, 7)), 8'($urandom));
      do_txn(rm, rix, 8'($urandom), 8'($urandom), 1'($urandom),
             (rm == 2'b01) && ($urandom_range(0, 1) == 1), int'($urandom_range(0, 6)));
    end
    check_shadow("shadow_rand");

    // reset while waiting for ack
    @(negedge clk);
    start = 1'b1; mode = 2'b00; base_addr = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstw_req", {31'd0, req}, 32'd0);
    chk("rstw_busy", {31'd0, busy}, 32'd0);
    chk("rstw_done", {31'd0, done}, 32'd0);
    chk("rstw_err", {31'd0, err}, 32'd0);
    for (int i = 0; i < 8; i++) sh_m[i] = 8'd0;
    check_shadow("shadow_rst");
    for (int k = 0; k < NCH; k++) begin dly[k] = 1; rdat[k] = 8'(8'h60 + k); end
    do_txn(2'b00, 0, 8'h10, 8'h00, 1'b0, 1'b0, 0);
    check_shadow("shadow_post");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
